// File: rtl/program_memory_loader.sv
// Program memory for the BIP core with a byte-serial load port and a
// registered fetch port. A bootloader streams a program in (MSB byte of each
// word first). The fetch side is serviced only once a complete program is
// present. Fetches past the loaded length return an all-zero NOP word.
module program_memory_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  load_byte_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  state_run
);
    localparam int                  BPW       = DATA_WIDTH / 8;
    localparam int                  BCW       = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LEN_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [BCW-1:0]      BCNT_ONE  = BCW'(1);
    localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
    logic [ADDR_WIDTH:0]   tgt_len_q, tgt_len_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic                  load_ready_q, load_ready_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;
    logic                  state_run_q, state_run_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  fetch_zero_q, fetch_zero_d;

    // No reset on the array or its read register so it maps onto block RAM
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word_q;

    logic                  byte_acc;
    logic                  word_full;
    logic                  fetch_acc;
    logic                  fetch_hit;
    logic [DATA_WIDTH-1:0] word_next;

    // Datapath strobes shared by the FSM and the RAM port
    always_comb begin
        byte_acc  = load_ready_q & load_byte_valid;
        word_next = DATA_WIDTH'({asm_q, load_byte});
        word_full = byte_acc && (bcnt_q == LAST_BYTE);
        fetch_acc = fetch_req && (state_q == S_RUN);
        // prog_len never exceeds DEPTH, so this also rejects addr >= DEPTH
        fetch_hit = fetch_acc && ({1'b0, fetch_addr} < prog_len_q);
    end

    // Next-state logic for the load FSM and the fetch response flags
    always_comb begin
        state_d       = state_q;
        prog_len_d    = prog_len_q;
        tgt_len_d     = tgt_len_q;
        wptr_d        = wptr_q;
        bcnt_d        = bcnt_q;
        asm_d         = asm_q;
        load_done_d   = 1'b0;
        load_error_d  = 1'b0;
        fetch_valid_d = fetch_acc;
        // A zero flag instead of a reset on the RAM output keeps fetch_data
        // at 0 after reset and for out-of-range fetches
        fetch_zero_d  = fetch_acc ? !fetch_hit : fetch_zero_q;

        case (state_q)
            S_EMPTY, S_RUN: begin
                if (load_start) begin
                    if (load_len == '0 || load_len > DEPTH_L) begin
                        load_error_d = 1'b1;
                    end else begin
                        state_d    = S_LOAD;
                        prog_len_d = '0;
                        tgt_len_d  = load_len;
                        wptr_d     = '0;
                        bcnt_d     = '0;
                    end
                end
            end
            S_LOAD: begin
                if (byte_acc) begin
                    asm_d = word_next;
                    if (word_full) begin
                        bcnt_d     = '0;
                        wptr_d     = wptr_q + PTR_ONE;
                        prog_len_d = prog_len_q + LEN_ONE;
                        if (prog_len_q + LEN_ONE == tgt_len_q) begin
                            state_d     = S_RUN;
                            load_done_d = 1'b1;
                        end
                    end else begin
                        bcnt_d = bcnt_q + BCNT_ONE;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase

        load_ready_d = (state_d == S_LOAD);
        state_run_d  = (state_d == S_RUN);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_EMPTY;
            prog_len_q    <= '0;
            tgt_len_q     <= '0;
            wptr_q        <= '0;
            bcnt_q        <= '0;
            asm_q         <= '0;
            load_ready_q  <= 1'b0;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
            state_run_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_zero_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            prog_len_q    <= prog_len_d;
            tgt_len_q     <= tgt_len_d;
            wptr_q        <= wptr_d;
            bcnt_q        <= bcnt_d;
            asm_q         <= asm_d;
            load_ready_q  <= load_ready_d;
            load_done_q   <= load_done_d;
            load_error_q  <= load_error_d;
            state_run_q   <= state_run_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_zero_q  <= fetch_zero_d;
        end
    end

    // Program RAM: word write on the last byte, synchronous read on fetch
    always_ff @(posedge clk) begin
        if (word_full) begin
            mem[wptr_q] <= word_next;
        end
        if (fetch_hit) begin
            rd_word_q <= mem[fetch_addr];
        end
    end

    assign fetch_data  = fetch_zero_q ? '0 : rd_word_q;
    assign fetch_valid = fetch_valid_q;
    assign load_ready  = load_ready_q;
    assign load_done   = load_done_q;
    assign load_error  = load_error_q;
    assign prog_len    = prog_len_q;
    assign state_run   = state_run_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader: one default-size instance (16b x 2048)
// and one 24b x 16 instance, each checked every cycle against a
// word/byte-level model, plus directed literal expectations.
module tb_program_memory_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;

    // instance A: DATA_WIDTH 16, ADDR_WIDTH 11, DEPTH 2048
    logic        a_fr = 0, a_ls = 0, a_bv = 0;
    logic [10:0] a_fa = '0;
    logic [11:0] a_ll = '0;
    logic [7:0]  a_b  = '0;
    logic [15:0] a_fd;
    logic        a_fv, a_rdy, a_done, a_err, a_run;
    logic [11:0] a_pl;

    // instance B: DATA_WIDTH 24, ADDR_WIDTH 4, DEPTH 16
    logic        b_fr = 0, b_ls = 0, b_bv = 0;
    logic [3:0]  b_fa = '0;
    logic [4:0]  b_ll = '0;
    logic [7:0]  b_b  = '0;
    logic [23:0] b_fd;
    logic        b_fv, b_rdy, b_done, b_err, b_run;
    logic [4:0]  b_pl;

    program_memory_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .DEPTH(2048)) u_a (
        .clk(clk), .reset_n(reset_n), .fetch_req(a_fr), .fetch_addr(a_fa),
        .fetch_data(a_fd), .fetch_valid(a_fv), .load_start(a_ls), .load_len(a_ll),
        .load_byte_valid(a_bv), .load_byte(a_b), .load_ready(a_rdy),
        .load_done(a_done), .load_error(a_err), .prog_len(a_pl), .state_run(a_run));

    program_memory_loader #(.DATA_WIDTH(24), .ADDR_WIDTH(4), .DEPTH(16)) u_b (
        .clk(clk), .reset_n(reset_n), .fetch_req(b_fr), .fetch_addr(b_fa),
        .fetch_data(b_fd), .fetch_valid(b_fv), .load_start(b_ls), .load_len(b_ll),
        .load_byte_valid(b_bv), .load_byte(b_b), .load_ready(b_rdy),
        .load_done(b_done), .load_error(b_err), .prog_len(b_pl), .state_run(b_run));

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- model: program as a word array, bytes as a shift ----
    localparam int BPW_M[2] = '{2, 3};
    localparam int DEP_M[2] = '{2048, 16};
    localparam int DW_M[2]  = '{16, 24};
    // mode: 0 = no program, 1 = loading, 2 = program present
    int          m_mode[2], m_len[2], m_tgt[2], m_nb[2];
    int unsigned m_asm[2];
    logic [23:0] mem_m[2][2048];
    logic [23:0] e_fd[2];
    bit          e_fv[2], e_done[2], e_err[2];

    task automatic model_reset(input int k);
        m_mode[k] = 0; m_len[k] = 0; m_tgt[k] = 0; m_nb[k] = 0; m_asm[k] = 0;
        e_fd[k] = '0; e_fv[k] = 0; e_done[k] = 0; e_err[k] = 0;
    endtask

    task automatic model_step(input int k, input bit fr, input int fa, input bit ls,
                              input int ll, input bit bv, input int b);
        e_fv[k] = 0; e_done[k] = 0; e_err[k] = 0;
        // fetch sees the program as it stood before this edge
        if (fr && m_mode[k] == 2) begin
            e_fv[k] = 1;
            e_fd[k] = (fa < m_len[k]) ? mem_m[k][fa] : 24'h0;
        end
        if (m_mode[k] != 1) begin
            if (ls) begin
                if (ll < 1 || ll > DEP_M[k]) e_err[k] = 1;
                else begin
                    m_mode[k] = 1; m_len[k] = 0; m_tgt[k] = ll; m_nb[k] = 0;
                end
            end
        end else if (bv) begin
            m_asm[k] = ((m_asm[k] << 8) | b) & ((32'd1 << DW_M[k]) - 1);
            m_nb[k]++;
            if (m_nb[k] == BPW_M[k]) begin
                mem_m[k][m_len[k]] = 24'(m_asm[k]);
                m_len[k]++;
                m_nb[k] = 0;
                if (m_len[k] == m_tgt[k]) begin
                    m_mode[k] = 2;
                    e_done[k] = 1;
                end
            end
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0, a_fr, int'(a_fa), a_ls, int'(a_ll), a_bv, int'(a_b));
                model_step(1, b_fr, int'(b_fa), b_ls, int'(b_ll), b_bv, int'(b_b));
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(posedge clk);
            #3;
            chk("A_fetch_valid", 32'(a_fv), 32'(e_fv[0]));
            chk("A_fetch_data", 32'(a_fd), 32'(e_fd[0][15:0]));
            chk("A_load_ready", 32'(a_rdy), 32'(m_mode[0] == 1));
            chk("A_load_done", 32'(a_done), 32'(e_done[0]));
            chk("A_load_error", 32'(a_err), 32'(e_err[0]));
            chk("A_prog_len", 32'(a_pl), 32'(m_len[0]));
            chk("A_state_run", 32'(a_run), 32'(m_mode[0] == 2));
            chk("B_fetch_valid", 32'(b_fv), 32'(e_fv[1]));
            chk("B_fetch_data", 32'(b_fd), 32'(e_fd[1]));
            chk("B_load_ready", 32'(b_rdy), 32'(m_mode[1] == 1));
            chk("B_load_done", 32'(b_done), 32'(e_done[1]));
            chk("B_load_error", 32'(b_err), 32'(e_err[1]));
            chk("B_prog_len", 32'(b_pl), 32'(m_len[1]));
            chk("B_state_run", 32'(b_run), 32'(m_mode[1] == 2));
            if (a_done) done_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic a_fetch1(input logic [10:0] addr, input logic [15:0] exp, input string nm);
        a_fr = 1; a_fa = addr;
        cyc();
        a_fr = 0;
        chk({nm, "_valid"}, 32'(a_fv), 32'd1);
        chk({nm, "_data"}, 32'(a_fd), 32'(exp));
    endtask

    function automatic logic [23:0] b_word(input int i);
        return {8'(i * 7 + 1), 8'(i ^ 8'hA5), 8'(8'hF0 - i)};
    endfunction

    initial begin
        logic [15:0] exp4[4];
        logic [23:0] w;
        int d0;
        exp4 = '{16'h0805, 16'h1803, 16'h0001, 16'h0000};

        // 1: reset state, fetch while empty
        repeat (3) cyc();
        chk("rst_fetch_data", 32'(a_fd), 32'd0);
        chk("rst_fetch_valid", 32'(a_fv), 32'd0);
        chk("rst_load_ready", 32'(a_rdy), 32'd0);
        chk("rst_prog_len", 32'(a_pl), 32'd0);
        chk("rst_state_run", 32'(a_run), 32'd0);
        chk("rst_B_fetch_data", 32'(b_fd), 32'd0);
        reset_n = 1;
        cyc();
        a_fr = 1; a_fa = '0;
        repeat (5) begin
            cyc();
            chk("t1_empty_no_valid", 32'(a_fv), 32'd0);
        end
        a_fr = 0;

        // 2: load 3 words with gaps between bytes
        d0 = done_cnt;
        cyc();
        a_ls = 1; a_ll = 12'd3;
        cyc();
        a_ls = 0;
        chk("t2_load_ready", 32'(a_rdy), 32'd1);
        foreach (exp4[i]) begin
            if (i < 3) begin
                w = {8'h0, exp4[i]};
                a_bv = 1; a_b = w[15:8]; cyc(); a_bv = 0; cyc();
                a_bv = 1; a_b = w[7:0];  cyc(); a_bv = 0; cyc();
            end
        end
        cyc();
        chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
        chk("t2_prog_len", 32'(a_pl), 32'd3);
        chk("t2_state_run", 32'(a_run), 32'd1);
        a_fr = 1; a_fa = 11'd0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t2_b2b_valid", 32'(a_fv), 32'd1);
            chk("t2_b2b_data", 32'(a_fd), 32'(exp4[i]));
            if (i < 3) a_fa = 11'(i + 1);
            else a_fr = 0;
            cyc();
        end
        chk("t2_valid_drops", 32'(a_fv), 32'd0);

        // 3: rejected loads
        a_ls = 1; a_ll = 12'd0;
        cyc();
        a_ls = 0;
        chk("t3_err_len0", 32'(a_err), 32'd1);
        cyc();
        chk("t3_err_len0_pulse", 32'(a_err), 32'd0);
        a_ls = 1; a_ll = 12'd2049;
        cyc();
        a_ls = 0;
        chk("t3_err_len2049", 32'(a_err), 32'd1);
        cyc();
        chk("t3_err_len2049_pulse", 32'(a_err), 32'd0);
        chk("t3_prog_len", 32'(a_pl), 32'd3);
        chk("t3_state_run", 32'(a_run), 32'd1);
        a_fetch1(11'd1, 16'h1803, "t3_fetch1");
        a_fetch1(11'd2047, 16'h0000, "t3_fetch_top");

        // 4: fetch on the load_start edge, then reset mid-load
        a_ls = 1; a_ll = 12'd2; a_fr = 1; a_fa = 11'd0;
        cyc();
        a_ls = 0; a_fr = 0;
        chk("t4_old_fetch_valid", 32'(a_fv), 32'd1);
        chk("t4_old_fetch_data", 32'(a_fd), 32'h0805);
        chk("t4_in_load", 32'(a_rdy), 32'd1);
        chk("t4_len_cleared", 32'(a_pl), 32'd0);
        a_bv = 1; a_b = 8'h11; cyc();
        a_b = 8'h22; cyc();
        a_b = 8'h33; cyc();
        a_bv = 0;
        reset_n = 0;
        cyc();
        chk("t4_rst_prog_len", 32'(a_pl), 32'd0);
        chk("t4_rst_run", 32'(a_run), 32'd0);
        chk("t4_rst_ready", 32'(a_rdy), 32'd0);
        reset_n = 1;
        cyc();
        a_fr = 1; a_fa = 11'd0;
        cyc();
        chk("t4_empty_no_valid", 32'(a_fv), 32'd0);
        cyc();
        a_fr = 0;
        chk("t4_empty_no_valid2", 32'(a_fv), 32'd0);

        // 5: one-word reload
        a_ls = 1; a_ll = 12'd1;
        cyc();
        a_ls = 0;
        a_bv = 1; a_b = 8'hAA; cyc();
        a_b = 8'h55; cyc();
        a_bv = 0;
        chk("t5_done", 32'(a_done), 32'd1);
        chk("t5_run", 32'(a_run), 32'd1);
        chk("t5_prog_len", 32'(a_pl), 32'd1);
        a_fetch1(11'd0, 16'hAA55, "t5_fetch0");
        a_fetch1(11'd1, 16'h0000, "t5_fetch1");

        // 6: 24-bit x 16 instance, full depth
        b_ls = 1; b_ll = 5'd17;
        cyc();
        b_ls = 0;
        chk("t6_err_len17", 32'(b_err), 32'd1);
        b_ls = 1; b_ll = 5'd16;
        cyc();
        b_ls = 0;
        for (int i = 0; i < 16; i++) begin
            w = b_word(i);
            for (int j = 0; j < 3; j++) begin
                b_bv = 1; b_b = w[23 - 8 * j -: 8];
                cyc();
            end
        end
        b_bv = 0;
        chk("t6_done", 32'(b_done), 32'd1);
        chk("t6_prog_len", 32'(b_pl), 32'd16);
        b_fr = 1; b_fa = 4'd0;
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk("t6_valid", 32'(b_fv), 32'd1);
            chk("t6_data", 32'(b_fd), 32'(b_word(i)));
            if (i < 15) b_fa = 4'(i + 1);
            else b_fr = 0;
            cyc();
        end
        b_fr = 1; b_fa = 4'd15;
        cyc();
        b_fr = 0;
        chk("t6_last_word", 32'(b_fd), 32'h6A_AA_E1);

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
Parametrised program memory for the BIP core, replacing the fixed 2K x 16 asynchronous-read ROM.
- Adds a byte-serial load port, so a bootloader (e.g. UART receiver) can write a program at run time.
- Adds a registered fetch port with request/valid handshake.
- Sits between the bootloader and the CPU instruction fetch stage.
- Tracks the loaded program length; fetches beyond it return a NOP (all-zero) word.

Parameters:
DATA_WIDTH, 16, instruction word width; must be a multiple of 8.
ADDR_WIDTH, 11, fetch address width.
DEPTH, 2048, number of words; must be <= 2**ADDR_WIDTH.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request, sampled on clk
fetch_addr  in  ADDR_WIDTH  word address, sampled with fetch_req
fetch_data  out  DATA_WIDTH  fetched instruction word
fetch_valid  out  1  fetch_data valid, 1-cycle pulse per accepted request
load_start  in  1  begin a program load
load_len  in  ADDR_WIDTH+1  number of words to load, sampled with load_start
load_byte_valid  in  1  load_byte valid this cycle
load_byte  in  8  program byte, MSB byte of each word first
load_ready  out  1  high while in LOAD; bytes accepted only when high
load_done  out  1  1-cycle pulse when the last word is written
load_error  out  1  1-cycle pulse on a rejected load_start
prog_len  out  ADDR_WIDTH+1  words in the currently valid program
state_run  out  1  high in RUN

Behaviour:
- Reset (async assert, sync release) drives all outputs to 0:
  - fetch_data, fetch_valid, load_ready, load_done, load_error, prog_len, state_run all 0.
  - FSM goes to EMPTY.
  - Memory array is not cleared; it is inferred block RAM with no reset.
- States:
  - EMPTY: no program; fetches not serviced.
  - LOAD: accepting bytes.
  - RUN: fetches serviced.
- Transitions:
  - EMPTY/RUN + load_start with 1 <= load_len <= DEPTH -> LOAD. On that edge: prog_len <= 0, word pointer <= 0, byte counter <= 0.
  - EMPTY/RUN + load_start with load_len == 0 or load_len > DEPTH -> load_error pulses next cycle; state and prog_len unchanged.
  - LOAD + load_start: ignored, no error.
  - LOAD: when the last byte of word (load_len-1) is accepted -> RUN. load_done pulses in the same cycle state_run rises.
- Byte assembly, each accepted byte (load_ready & load_byte_valid):
  - Shifts into a DATA_WIDTH assembly register, MSB byte first.
  - On the (DATA_WIDTH/8)-th byte, the full word is written at the word pointer in that same clock edge.
  - Then the pointer increments, prog_len increments, and the byte counter resets.
  - Gaps between bytes of any length are allowed.
- Fetch:
  - fetch_req at edge t, in RUN only -> fetch_data and fetch_valid registered at edge t+1. Latency 1.
  - Back-to-back requests every cycle give one valid per cycle.
  - fetch_addr >= prog_len -> fetch_data = 0, fetch_valid = 1.
  - fetch_addr >= DEPTH behaves the same way (no wrap).
  - fetch_req in EMPTY or LOAD -> fetch_valid stays 0 and fetch_data holds its last value.
  - A fetch accepted on the same edge that a load_start is accepted still completes with the old contents.
- Simultaneous write and read of the same address while in LOAD cannot occur, because fetch is blocked in LOAD.
- Reset mid-load:
  - Returns to EMPTY with prog_len = 0.
  - Partial contents are abandoned; a new full load is required.
- fetch_valid, load_done and load_error are never high for more than one consecutive cycle per triggering event.

Test Plan:
1. Reset -> all outputs 0, state_run = 0. Then fetch_req with addr 0 -> fetch_valid stays 0 for 5 cycles.
2. load_start with len 3, then bytes 08 05 18 03 00 01 with 1-cycle gaps.
   - load_done pulses once after the 6th byte.
   - prog_len = 3, state_run = 1.
   - Fetches of addr 0, 1, 2, 3 back-to-back -> 0x0805, 0x1803, 0x0001, 0x0000, each valid one cycle after its request.
3. load_start with len 0, then with len 2049 (DEPTH = 2048) -> load_error pulses each time; state_run, prog_len = 3 and contents unchanged.
4. In LOAD with 3 of 4 bytes sent, assert reset_n = 0 -> state EMPTY, prog_len = 0. Fetch of addr 0 -> no valid.
5. Reload with len 1 and bytes AA 55 -> fetch addr 0 = 0xAA55. Fetch addr 1 -> 0x0000 (beyond prog_len).
6. Parameter sweep with DATA_WIDTH = 24, ADDR_WIDTH = 4, DEPTH = 16: load 16 words (3 bytes each) -> all 16 read back correctly. Fetch addr 15 -> last word loaded.
